// File: rtl/rect_renderer_if.sv
// Command handshake and framebuffer write port of the rectangle renderer.
// The renderer is the slave side: it takes commands and drives the writes.
interface rect_renderer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x0;
    logic [7:0]        cmd_y0;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic [ADDR_W-1:0] addrWrite;
    logic [DATA_W-1:0] dataWrite;
    logic              wr_valid;
    logic              busy;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, addrWrite, dataWrite, wr_valid, busy
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output cmd_ready, addrWrite, dataWrite, wr_valid, busy
    );
endinterface

// File: rtl/rect_renderer.sv
// Rectangle-fill rasterizer feeding the ping-pong framebuffer write port.
// One pixel per clock in raster order; address = y*H_RES + x.
// Optional feature macro RENDER_CLIP_EN: clip rectangles at the right/bottom
// edge. Without it, any rectangle crossing an edge is dropped as empty.
module rect_renderer #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rect_renderer_if.slave     bus
);
    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t            state;
    logic [8:0]        xCnt;
    logic [8:0]        xStart;
    logic [7:0]        yCnt;
    logic [9:0]        xEnd;
    logic [9:0]        yEnd;
    logic [DATA_W-1:0] colorReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] dataReg;
    logic              validReg;

    logic [9:0]        xSum;
    logic [9:0]        ySum;
    logic [9:0]        xLim;
    logic [9:0]        yLim;
    logic              cmdEmpty;
    logic              xLast;
    logic              yLast;
    logic [ADDR_W-1:0] pixAddr;

    // Bounds of the incoming command, evaluated in 10-bit arithmetic.
    always_comb begin
        xSum     = {1'b0, bus.cmd_x0} + {1'b0, bus.cmd_w};
        ySum     = {2'b0, bus.cmd_y0} + {2'b0, bus.cmd_h};
        cmdEmpty = (bus.cmd_w == 9'd0) || (bus.cmd_h == 8'd0) ||
                   ({1'b0, bus.cmd_x0} >= H_LIM) || ({2'b0, bus.cmd_y0} >= V_LIM);
`ifdef RENDER_CLIP_EN
        xLim = (xSum > H_LIM) ? H_LIM : xSum;
        yLim = (ySum > V_LIM) ? V_LIM : ySum;
`else
        xLim = xSum;
        yLim = ySum;
        if ((xSum > H_LIM) || (ySum > V_LIM)) begin
            cmdEmpty = 1'b1;
        end
`endif
    end

    // Raster position decode; the multiply by 320 is two shifts and an add.
    always_comb begin
        xLast   = (({1'b0, xCnt} + 10'd1) == xEnd);
        yLast   = (({2'b0, yCnt} + 10'd1) == yEnd);
        pixAddr = (ADDR_W'(yCnt) << 8) + (ADDR_W'(yCnt) << 6) + ADDR_W'(xCnt);
    end

    // Command acceptance, raster walk and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            xCnt     <= '0;
            xStart   <= '0;
            yCnt     <= '0;
            xEnd     <= '0;
            yEnd     <= '0;
            colorReg <= '0;
            addrReg  <= '0;
            dataReg  <= '0;
            validReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    validReg <= 1'b0;
                    if (bus.cmd_valid) begin
                        colorReg <= bus.cmd_color;
                        xStart   <= bus.cmd_x0;
                        xCnt     <= bus.cmd_x0;
                        yCnt     <= bus.cmd_y0;
                        xEnd     <= xLim;
                        yEnd     <= yLim;
                        if (!cmdEmpty) begin
                            state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    addrReg  <= pixAddr;
                    dataReg  <= colorReg;
                    validReg <= 1'b1;
                    if (xLast) begin
                        xCnt <= xStart;
                        yCnt <= yCnt + 8'd1;
                        if (yLast) begin
                            state <= IDLE;
                        end
                    end else begin
                        xCnt <= xCnt + 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.addrWrite = addrReg;
    assign bus.dataWrite = dataReg;
    assign bus.wr_valid  = validReg;
endmodule

// File: tb/tb_rect_renderer.sv
// Directed bench for rect_renderer: captures every written pixel with its
// cycle number and compares against hand-computed address sequences.
module tb_rect_renderer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   nCompared;
    int   nMismatched;

    int   addrQ[$];
    int   dataQ[$];
    int   cycQ[$];
    int   readyQ[$];

    rect_renderer_if #(.ADDR_W(20), .DATA_W(8)) bus ();

    rect_renderer #(.H_RES(320), .V_RES(240), .ADDR_W(20), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel capture, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.wr_valid) begin
            addrQ.push_back(int'(bus.addrWrite));
            dataQ.push_back(int'(bus.dataWrite));
            cycQ.push_back(cyc);
            readyQ.push_back(int'(bus.cmd_ready));
        end
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearQ();
        addrQ.delete();
        dataQ.delete();
        cycQ.delete();
        readyQ.delete();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sendCmd(input logic [8:0] x0, input logic [7:0] y0,
                           input logic [8:0] w, input logic [7:0] h,
                           input logic [7:0] color, input string tag,
                           output int acceptCyc);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_x0    = x0;
        bus.cmd_y0    = y0;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, "_accept_timeout"}, int'(n >= 200), 0);
        @(posedge clk);
        #1;
        acceptCyc     = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitPixels(input int target, input int maxCycles, input string tag);
        int n;
        n = 0;
        while (addrQ.size() < target && n < maxCycles) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkVal({tag, "_pixel_timeout"}, int'(addrQ.size() < target), 0);
    endtask

    initial begin
        int acc;
        int acc2;
        int breaks;
        int exp1[6];
        int expClip[4];

        nCompared     = 0;
        nMismatched   = 0;
        cyc           = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;

        // Reset state
        rst_n = 1'b0;
        #23;
        checkVal("rst_addr",  int'(bus.addrWrite), 0);
        checkVal("rst_data",  int'(bus.dataWrite), 0);
        checkVal("rst_valid", int'(bus.wr_valid), 0);
        checkVal("rst_ready", int'(bus.cmd_ready), 1);
        checkVal("rst_busy",  int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        // Basic 3x2 rectangle
        clearQ();
        exp1 = '{1610, 1611, 1612, 1930, 1931, 1932};
        sendCmd(9'd10, 8'd5, 9'd3, 8'd2, 8'hA5, "r3x2", acc);
        checkVal("r3x2_ready_after_accept", int'(bus.cmd_ready), 0);
        checkVal("r3x2_busy_after_accept",  int'(bus.busy), 1);
        waitPixels(6, 50, "r3x2");
        idleCycles(5);
        checkVal("r3x2_count", addrQ.size(), 6);
        if (addrQ.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checkVal($sformatf("r3x2_addr%0d", i), addrQ[i], exp1[i]);
                checkVal($sformatf("r3x2_data%0d", i), dataQ[i], 8'hA5);
            end
            checkVal("r3x2_latency",  cycQ[0] - acc, 1);
            checkVal("r3x2_contig",   cycQ[5] - cycQ[0], 5);
            checkVal("r3x2_ready_p5", readyQ[4], 0);
            checkVal("r3x2_ready_p6", readyQ[5], 1);
        end

        // Full screen
        clearQ();
        sendCmd(9'd320, 8'd0, 9'd0, 8'd0, 8'h00, "dummy_empty", acc);
        sendCmd(9'd0, 8'd0, 9'd320, 8'd240, 8'h00, "full", acc);
        waitPixels(76800, 77000, "full");
        idleCycles(4);
        checkVal("full_count", addrQ.size(), 76800);
        if (addrQ.size() == 76800) begin
            breaks = 0;
            for (int i = 1; i < 76800; i++) begin
                if (addrQ[i] != addrQ[i-1] + 1 || cycQ[i] != cycQ[i-1] + 1) breaks++;
            end
            checkVal("full_first", addrQ[0], 0);
            checkVal("full_last",  addrQ[76799], 76799);
            checkVal("full_seq_breaks", breaks, 0);
            checkVal("full_data_last", dataQ[76799], 0);
            checkVal("full_end_cycle", cycQ[76799] - acc, 76800);
        end
        checkVal("full_ready_after", int'(bus.cmd_ready), 1);

        // Clip at bottom-right corner
        clearQ();
        expClip = '{76478, 76479, 76798, 76799};
        sendCmd(9'd318, 8'd238, 9'd5, 8'd5, 8'h3C, "clip", acc);
`ifdef RENDER_CLIP_EN
        checkVal("clip_ready_after_accept", int'(bus.cmd_ready), 0);
        waitPixels(4, 50, "clip");
        idleCycles(5);
        checkVal("clip_count", addrQ.size(), 4);
        if (addrQ.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkVal($sformatf("clip_addr%0d", i), addrQ[i], expClip[i]);
                checkVal($sformatf("clip_data%0d", i), dataQ[i], 8'h3C);
            end
        end
`else
        checkVal("clip_ready_after_accept", int'(bus.cmd_ready), 1);
        idleCycles(10);
        checkVal("clip_count", addrQ.size(), 0);
        checkVal("clip_ready_idle", int'(bus.cmd_ready), 1);
        checkVal("clip_ref_unused", expClip[0], 76478);
`endif

        // Empty commands
        clearQ();
        sendCmd(9'd5, 8'd5, 9'd0, 8'd3, 8'h99, "empty_w0", acc);
        checkVal("empty_w0_ready", int'(bus.cmd_ready), 1);
        sendCmd(9'd320, 8'd0, 9'd4, 8'd4, 8'h99, "empty_x320", acc2);
        checkVal("empty_x320_ready", int'(bus.cmd_ready), 1);
        checkVal("empty_handshake_spacing", acc2 - acc, 1);
        idleCycles(8);
        checkVal("empty_count", addrQ.size(), 0);
        checkVal("empty_valid", int'(bus.wr_valid), 0);

        // Back-to-back with cmd_valid held high
        clearQ();
        @(negedge clk);
        bus.cmd_x0 = 9'd0; bus.cmd_y0 = 8'd0; bus.cmd_w = 9'd2; bus.cmd_h = 8'd1;
        bus.cmd_color = 8'h11; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_x0 = 9'd0; bus.cmd_y0 = 8'd1; bus.cmd_w = 9'd2; bus.cmd_h = 8'd1;
        bus.cmd_color = 8'h22;
        acc = 0;
        while (acc < 50) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            acc++;
        end
        checkVal("b2b_ready_timeout", int'(acc >= 50), 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = 9'd100; bus.cmd_y0 = 8'd100; bus.cmd_color = 8'hFF;
        waitPixels(4, 50, "b2b");
        idleCycles(5);
        checkVal("b2b_count", addrQ.size(), 4);
        if (addrQ.size() == 4) begin
            checkVal("b2b_addr0", addrQ[0], 0);
            checkVal("b2b_addr1", addrQ[1], 1);
            checkVal("b2b_addr2", addrQ[2], 320);
            checkVal("b2b_addr3", addrQ[3], 321);
            checkVal("b2b_data1", dataQ[1], 8'h11);
            checkVal("b2b_data3", dataQ[3], 8'h22);
            checkVal("b2b_step01", cycQ[1] - cycQ[0], 1);
            checkVal("b2b_gap",    cycQ[2] - cycQ[1], 2);
            checkVal("b2b_step23", cycQ[3] - cycQ[2], 1);
        end

        // Reset during a 4x4 draw
        clearQ();
        sendCmd(9'd0, 8'd0, 9'd4, 8'd4, 8'h77, "abort", acc);
        waitPixels(3, 20, "abort");
        rst_n = 1'b0;
        #1;
        checkVal("abort_valid", int'(bus.wr_valid), 0);
        checkVal("abort_addr",  int'(bus.addrWrite), 0);
        checkVal("abort_data",  int'(bus.dataWrite), 0);
        checkVal("abort_ready_in_rst", int'(bus.cmd_ready), 1);
        idleCycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(10);
        checkVal("abort_ready_after", int'(bus.cmd_ready), 1);
        checkVal("abort_count", addrQ.size(), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
